// File: rtl/snes_pad_responder.sv
// snes_pad_responder: SNES pad emulator shifting a 16-bit button frame on latch/pulse polls; autofire built only with SNES_PAD_TURBO_EN
module snes_pad_responder #(
    parameter int          TURBO_DIV  = 4,
    parameter logic [11:0] TURBO_MASK = 12'h000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        lat,
    input  logic        pulse,
    input  logic [11:0] buttons,
    output logic        data,
    output logic        frame_strobe,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
    state_t      r_state;
    logic [2:0]  r_lat;
    logic [2:0]  r_pul;
    logic [4:0]  r_idx;
    logic [15:0] r_shreg;
    logic [15:0] w_load;
    logic [4:0]  w_next;
    logic        w_lat;
    logic        w_lat_fall;
    logic        w_pul_rise;
    assign w_lat      = r_lat[1];
    assign w_lat_fall = r_lat[2] & ~r_lat[1];
    assign w_pul_rise = r_pul[1] & ~r_pul[2];
    assign w_next     = r_idx + 5'd1;
`ifdef SNES_PAD_TURBO_EN
    localparam int TW = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;
    logic [TW-1:0] r_tcnt;
    logic          r_phase;
    logic          w_lat_rise;
    assign w_lat_rise = r_lat[1] & ~r_lat[2];
    assign w_load     = {4'h0, buttons & ~(TURBO_MASK & {12{r_phase}})};
    // autofire phase flips every TURBO_DIV latch frames
    always_ff @(posedge clock) begin
        if (reset) begin
            r_tcnt  <= '0;
            r_phase <= 1'b0;
        end else if (w_lat_rise) begin
            if (r_tcnt == TW'(TURBO_DIV - 1)) begin
                r_tcnt  <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_tcnt <= r_tcnt + TW'(1);
            end
        end
    end
`else
    logic w_unused;
    assign w_unused = ^{TURBO_MASK, TURBO_DIV[0]};
    assign w_load   = {4'h0, buttons};
`endif
    // two-flop synchronizers plus a history flop for edge detection
    always_ff @(posedge clock) begin
        if (reset) begin
            r_lat <= '0;
            r_pul <= '0;
        end else begin
            r_lat <= {r_lat[1:0], lat};
            r_pul <= {r_pul[1:0], pulse};
        end
    end
    // frame state machine; latch overrides everything, outputs registered
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_shreg      <= '0;
            data         <= 1'b1;
            frame_strobe <= 1'b0;
            busy         <= 1'b0;
        end else begin
            frame_strobe <= 1'b0;
            if (w_lat) begin
                r_state <= LOAD;
                r_idx   <= '0;
                r_shreg <= w_load;
                data    <= ~w_load[0];
                busy    <= 1'b1;
            end else begin
                case (r_state)
                    IDLE: begin
                        data <= 1'b1;
                        busy <= 1'b0;
                    end
                    LOAD: begin
                        if (w_lat_fall) begin
                            r_state <= SHIFT;
                            r_idx   <= '0;
                            data    <= ~r_shreg[0];
                        end else begin
                            r_shreg <= w_load;
                            data    <= ~w_load[0];
                        end
                        busy <= 1'b1;
                    end
                    SHIFT: begin
                        if (w_pul_rise) begin
                            r_idx <= w_next;
                            if (w_next == 5'd16) begin
                                r_state      <= DONE;
                                data         <= 1'b0;
                                frame_strobe <= 1'b1;
                                busy         <= 1'b0;
                            end else begin
                                data <= ~r_shreg[w_next[3:0]];
                            end
                        end else begin
                            data <= ~r_shreg[r_idx[3:0]];
                        end
                    end
                    default: begin
                        data <= 1'b0;
                        busy <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_snes_pad_responder.sv
// tb_snes_pad_responder: host-side poll model checking the pad responder's serial frames
module tb_snes_pad_responder;
    localparam int          T_DIV  = 2;
    localparam logic [11:0] T_MASK = 12'h100;
    logic        clock;
    logic        reset;
    logic        lat;
    logic        pulse;
    logic [11:0] buttons;
    logic        data;
    logic        frame_strobe;
    logic        busy;
    int          n_chk;
    int          n_fail;
    int          n_strobe;
    int          m_rises;
    int          k;
    int          s0;
    logic        m_valid;
    logic        m_exp;
    logic        m_busy;
    logic        m_idle;
    logic [15:0] m_frame;
    logic [15:0] samp;
    logic [15:0] fr;
    logic [3:0]  tv;

    snes_pad_responder #(.TURBO_DIV(T_DIV), .TURBO_MASK(T_MASK)) dut (
        .clock(clock), .reset(reset), .lat(lat), .pulse(pulse), .buttons(buttons),
        .data(data), .frame_strobe(frame_strobe), .busy(busy)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // frame a host would read: buttons at latch release, autofire bits dropped on odd phases
    function automatic logic [15:0] model_frame(input logic [11:0] b);
        logic [11:0] m;
        m = b;
`ifdef SNES_PAD_TURBO_EN
        if (((m_rises / T_DIV) % 2) == 1) m = b & ~T_MASK;
`endif
        return {4'h0, m};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #3;
    endtask

    task automatic latch_frame(input int hw);
        m_valid = 1'b0;
        lat = 1'b1;
        m_rises++;
        m_idle = 1'b0;
        cyc(4);
        fr = model_frame(buttons);
        m_exp = ~fr[0];
        m_busy = 1'b1;
        m_valid = 1'b1;
        cyc(hw - 4);
        m_valid = 1'b0;
        m_frame = model_frame(buttons);
        lat = 1'b0;
        k = 0;
        cyc(4);
        m_exp = ~m_frame[0];
        m_valid = 1'b1;
        cyc(hw - 4);
    endtask

    task automatic pulse_once(input int hw);
        if (k < 16) samp[k] = data;
        m_valid = 1'b0;
        pulse = 1'b1;
        if (!m_idle && k < 16) k++;
        cyc(4);
        m_exp = m_idle ? 1'b1 : (k >= 16 ? 1'b0 : ~m_frame[k]);
        m_busy = !m_idle && k < 16;
        m_valid = 1'b1;
        cyc(hw - 4);
        pulse = 1'b0;
        cyc(hw);
    endtask

    // continuous comparison against the host model on the falling edge
    always @(negedge clock) begin
        if (frame_strobe) begin
            n_strobe++;
            chk("strobe_data", {31'b0, data}, 32'd0);
        end
        if (m_valid) begin
            chk("data", {31'b0, data}, {31'b0, m_exp});
            chk("busy", {31'b0, busy}, {31'b0, m_busy});
        end
    end

    initial begin
        n_chk = 0; n_fail = 0; n_strobe = 0; m_rises = 0; k = 0;
        reset = 1'b1; lat = 1'b0; pulse = 1'b0; buttons = '0;
        m_valid = 1'b0; m_exp = 1'b1; m_busy = 1'b0; m_idle = 1'b1;
        m_frame = '0; samp = '0; tv = '0;
        cyc(3);
        reset = 1'b0;
        m_valid = 1'b1;
        cyc(20);
        chk("idle_data", {31'b0, data}, 32'd1);
        chk("idle_busy", {31'b0, busy}, 32'd0);
        chk("idle_strobes", n_strobe, 0);
        buttons = 12'h201;
        s0 = n_strobe;
        latch_frame(600);
        repeat (16) pulse_once(150);
        chk("bx_bits", {16'b0, samp}, 32'h0000FDFE);
        chk("bx_strobe", n_strobe - s0, 1);
        chk("bx_done_data", {31'b0, data}, 32'd0);
        buttons = 12'h0A5;
        s0 = n_strobe;
        latch_frame(6);
        repeat (5) pulse_once(6);
        latch_frame(6);
        chk("abort_nostrobe", n_strobe - s0, 0);
        chk("abort_bit0", {31'b0, data}, 32'd0);
        repeat (16) pulse_once(6);
        chk("abort_bits", {16'b0, samp}, 32'h0000FF5A);
        chk("abort_strobe", n_strobe - s0, 1);
        buttons = 12'h001;
        latch_frame(6);
        buttons = 12'h000;
        repeat (16) pulse_once(6);
        chk("frozen_b", {31'b0, samp[0]}, 32'd0);
        buttons = 12'h0FF;
        s0 = n_strobe;
        latch_frame(6);
        repeat (8) pulse_once(6);
        m_valid = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("rst_data", {31'b0, data}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_strobe", {31'b0, frame_strobe}, 32'd0);
        cyc(1);
        reset = 1'b0;
        m_rises = 0;
        m_idle = 1'b1;
        m_exp = 1'b1;
        m_busy = 1'b0;
        m_valid = 1'b1;
        repeat (4) pulse_once(6);
        chk("rst_nostrobe", n_strobe - s0, 0);
        buttons = 12'h100;
        for (int f = 0; f < 4; f++) begin
            latch_frame(6);
            repeat (16) pulse_once(6);
            tv[f] = samp[8];
        end
`ifdef SNES_PAD_TURBO_EN
        chk("turbo_seq", {28'b0, tv}, 32'h6);
`else
        chk("turbo_seq", {28'b0, tv}, 32'h0);
`endif
        m_valid = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
